reorder_trace_sequencer: RTL and testbench
==========================================

Name: reorder_trace_sequencer

Overview:
- Front-end controller for reorder_logic_top.
- Accepts trace requests (ID plus entry count) and a stream of per-entry queue selectors. Sequences them onto the trace_id/trace push interface, applies backpressure from full and from an in-flight ID limit, and handles mid-trace abort via trace_update.
- Also drains the committed-ID queue into a registered valid/ready output port.

Parameters:
NUM_QUEUES, 4, number of reordered queues
DEPTH, 8, reorder entry depth; in-flight ID limit
MAX_ENTRIES, 8, maximum trace entries per ID
BREAKPOINT, 1'b1, value driven on trace_break_o for the final entry of a trace
(derived) ID_WIDTH=$clog2(DEPTH), SEL_WIDTH=$clog2(NUM_QUEUES), CNT_WIDTH=$clog2(MAX_ENTRIES+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, reset is synchronous and active-high
req_valid_i  in  1  trace request valid
req_ready_o  out  1  request accepted when valid&ready
req_id_i  in  ID_WIDTH  trace ID
req_count_i  in  CNT_WIDTH  number of entries, legal range 1..MAX_ENTRIES
sel_valid_i  in  1  selector stream valid
sel_ready_o  out  1  selector consumed when valid&ready
sel_i  in  SEL_WIDTH  queue selector for the next entry
abort_i  in  1  terminate current trace early
full_i  in  1  reorder logic full_o
trace_id_push_o  out  1  push ID (registered)
trace_id_value_o  out  ID_WIDTH  pushed ID
trace_push_o  out  1  push trace entry
trace_sel_o  out  SEL_WIDTH  entry queue selector
trace_break_o  out  1  breakpoint flag
trace_update_o  out  1  end-of-trace re-update pulse
commit_id_valid_i  in  1  committed-ID queue not empty (first-word fall-through)
commit_id_value_i  in  ID_WIDTH  oldest committed ID
commit_id_pull_o  out  1  pull committed ID
out_valid_o  out  1  drained ID valid
out_id_o  out  ID_WIDTH  drained ID
out_ready_i  in  1  consumer ready
busy_o  out  1  FSM not IDLE
err_o  out  1  one-cycle pulse on an illegal req_count_i

Behaviour:
- Reset (rst_i=1 at posedge): all outputs 0, FSM=IDLE, inflight=0, drain register empty.
  - Reset overrides every other event, including mid-trace; no trace_update_o pulse is generated and partial traces are discarded.
- FSM states: IDLE, ENTRY.
- IDLE:
  - req_ready_o = ~full_i & (inflight < DEPTH).
  - On handshake with req_count_i in 1..MAX_ENTRIES: latch ID, set remaining=req_count_i and first=1, go to ENTRY.
  - On handshake with req_count_i=0 or >MAX_ENTRIES: drop the request, pulse err_o the next cycle, stay in IDLE.
- ENTRY:
  - sel_ready_o = ~full_i & ~abort_i.
  - On selector handshake, the following cycle drives:
    - trace_push_o=1, trace_sel_o=sel_i;
    - trace_id_push_o=first, trace_id_value_o=latched ID;
    - trace_break_o=BREAKPOINT if remaining==1, else ~BREAKPOINT.
  - Each selector handshake clears first and decrements remaining. When remaining reaches 0, go to IDLE.
  - Selector-to-push latency is exactly 1 cycle. All trace outputs are 0 in cycles without a handshake.
  - full_i=1 stalls with no push; the FSM resumes the cycle after full_i deasserts.
- Abort:
  - abort_i in ENTRY with first=0: no push; trace_update_o=1 for one cycle; go to IDLE.
  - abort_i in ENTRY with first=1: go to IDLE silently, with no ID push and no update pulse.
  - abort_i in IDLE: ignored.
- In-flight counter:
  - +1 on trace_id_push_o, -1 on commit_id_pull_o; both in the same cycle leaves it unchanged.
  - Never exceeds DEPTH and never underflows; a pull when inflight=0 leaves it at 0.
- Commit drain:
  - commit_id_pull_o = commit_id_valid_i & (~out_valid_o | out_ready_i), combinational.
  - On pull: out_valid_o<=1, out_id_o<=commit_id_value_i.
  - Otherwise, on out_ready_i & out_valid_o: out_valid_o<=0.
  - Sustains one ID per cycle; out_id_o is held stable while out_valid_o & ~out_ready_i.
- busy_o = (FSM==ENTRY).

Test Plan:
- Req id=5, count=3, selectors 2,0,3 back-to-back -> pushes in 3 consecutive cycles with sel 2,0,3; trace_id_push_o=1 with value 5 on the first push only; trace_break_o=0,0,1.
- full_i=1 for cycles 2-4 of a count=4 trace -> no pushes while full, sel_ready_o=0, remaining entries pushed in order after release; exactly 4 pushes total.
- Issue 8 requests with count=1 and no commits -> inflight=8, req_ready_o=0; one commit pull -> req_ready_o=1 the next cycle.
- count=4, abort_i after 2 pushes -> trace_update_o single pulse, no further pushes, FSM IDLE; abort before the first selector -> no ID push, no pulse.
- req_count_i=0 and req_count_i=9 -> err_o one-cycle pulse each, no trace activity, FSM stays IDLE.
- Commit IDs 3,1,6 available with out_ready_i toggling 1,0,1,1 -> out_id_o sequence 3,1,6 with no loss or duplication; commit_id_pull_o=0 while out_valid_o&~out_ready_i.
- rst_i asserted mid-trace -> all outputs 0 the next cycle, inflight=0, no trace_update_o.

Source files
------------

// File: rtl/reorder_trace_sequencer_if.sv
// Handshake and bus bundle between the trace sequencer and its environment.
// The slave view belongs to the sequencer. The master view belongs to whatever
// drives requests and selectors and consumes the trace and drain outputs.
interface reorder_trace_sequencer_if #(
    parameter int NUM_QUEUES  = 4,
    parameter int DEPTH       = 8,
    parameter int MAX_ENTRIES = 8
);
    localparam int ID_WIDTH  = $clog2(DEPTH);
    localparam int SEL_WIDTH = $clog2(NUM_QUEUES);
    localparam int CNT_WIDTH = $clog2(MAX_ENTRIES + 1);

    // Trace request channel
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [ID_WIDTH-1:0]  req_id_i;
    logic [CNT_WIDTH-1:0] req_count_i;

    // Per-entry selector stream
    logic                 sel_valid_i;
    logic                 sel_ready_o;
    logic [SEL_WIDTH-1:0] sel_i;
    logic                 abort_i;

    // Push interface towards the reorder logic
    logic                 full_i;
    logic                 trace_id_push_o;
    logic [ID_WIDTH-1:0]  trace_id_value_o;
    logic                 trace_push_o;
    logic [SEL_WIDTH-1:0] trace_sel_o;
    logic                 trace_break_o;
    logic                 trace_update_o;

    // Committed-ID queue (first-word fall-through)
    logic                 commit_id_valid_i;
    logic [ID_WIDTH-1:0]  commit_id_value_i;
    logic                 commit_id_pull_o;

    // Drained-ID output port
    logic                 out_valid_o;
    logic [ID_WIDTH-1:0]  out_id_o;
    logic                 out_ready_i;

    // Status
    logic                 busy_o;
    logic                 err_o;

    modport slave (
        input  req_valid_i, req_id_i, req_count_i,
        input  sel_valid_i, sel_i, abort_i, full_i,
        input  commit_id_valid_i, commit_id_value_i, out_ready_i,
        output req_ready_o, sel_ready_o,
        output trace_id_push_o, trace_id_value_o, trace_push_o,
        output trace_sel_o, trace_break_o, trace_update_o,
        output commit_id_pull_o, out_valid_o, out_id_o,
        output busy_o, err_o
    );

    modport master (
        output req_valid_i, req_id_i, req_count_i,
        output sel_valid_i, sel_i, abort_i, full_i,
        output commit_id_valid_i, commit_id_value_i, out_ready_i,
        input  req_ready_o, sel_ready_o,
        input  trace_id_push_o, trace_id_value_o, trace_push_o,
        input  trace_sel_o, trace_break_o, trace_update_o,
        input  commit_id_pull_o, out_valid_o, out_id_o,
        input  busy_o, err_o
    );
endinterface

// File: rtl/reorder_trace_sequencer.sv
// Front-end controller for reorder_logic_top.
// Turns (ID, count) trace requests plus a selector stream into registered
// trace_id/trace pushes. Honours full_i, caps the number of IDs in flight and
// closes aborted traces with a trace_update pulse. Also drains the
// committed-ID queue into a registered valid/ready output.
module reorder_trace_sequencer #(
    parameter int   NUM_QUEUES  = 4,
    parameter int   DEPTH       = 8,
    parameter int   MAX_ENTRIES = 8,
    parameter logic BREAKPOINT  = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    reorder_trace_sequencer_if.slave bus
);
    localparam int ID_WIDTH  = $clog2(DEPTH);
    localparam int SEL_WIDTH = $clog2(NUM_QUEUES);
    localparam int CNT_WIDTH = $clog2(MAX_ENTRIES + 1);
    localparam int INF_WIDTH = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 first_q, first_d;

    // Registered trace outputs and their next values
    logic                 id_push_q, id_push_d;
    logic [ID_WIDTH-1:0]  id_value_q, id_value_d;
    logic                 push_q, push_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 break_q, break_d;
    logic                 update_q, update_d;
    logic                 err_q, err_d;

    // In-flight accounting and drain register
    logic [INF_WIDTH-1:0] inflight_q;
    logic [INF_WIDTH:0]   inflight_pending;
    logic                 req_ready;
    logic                 sel_ready;
    logic                 commit_pull;
    logic                 out_valid_q;
    logic [ID_WIDTH-1:0]  out_id_q;
    logic                 count_legal;

    // An ID push that is visible this cycle is not in inflight_q yet. It is
    // counted here anyway so that a request accepted in the same cycle cannot
    // push the in-flight total beyond DEPTH.
    assign inflight_pending = {1'b0, inflight_q} + {{INF_WIDTH{1'b0}}, id_push_q};

    assign count_legal = (bus.req_count_i != '0) &&
                         (bus.req_count_i <= CNT_WIDTH'(MAX_ENTRIES));

    assign commit_pull = bus.commit_id_valid_i & (~out_valid_q | bus.out_ready_i);

    // Next-state, handshake readies and next trace outputs for the sequencing FSM
    always_comb begin
        // NOTE: every signal written here receives a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        id_d        = id_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        req_ready   = 1'b0;
        sel_ready   = 1'b0;
        id_push_d   = 1'b0;
        id_value_d  = '0;
        push_d      = 1'b0;
        sel_d       = '0;
        break_d     = 1'b0;
        update_d    = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = ~bus.full_i &
                            (inflight_pending < (INF_WIDTH + 1)'(DEPTH));
                if (bus.req_valid_i && req_ready) begin
                    if (count_legal) begin
                        id_d        = bus.req_id_i;
                        remaining_d = bus.req_count_i;
                        first_d     = 1'b1;
                        state_d     = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ENTRY: begin
                sel_ready = ~bus.full_i & ~bus.abort_i;
                if (bus.abort_i) begin
                    // An aborted trace that already pushed its ID must be
                    // closed downstream; one that never started leaves no trace.
                    update_d = ~first_q;
                    state_d  = IDLE;
                end else if (bus.sel_valid_i && sel_ready) begin
                    push_d      = 1'b1;
                    sel_d       = bus.sel_i;
                    id_push_d   = first_q;
                    id_value_d  = id_q;
                    break_d     = (remaining_q == CNT_WIDTH'(1)) ? BREAKPOINT : ~BREAKPOINT;
                    first_d     = 1'b0;
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // FSM state and latched trace context
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q     <= IDLE;
            id_q        <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
        end
    end

    // Registered trace push outputs and the error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_push_q  <= 1'b0;
            id_value_q <= '0;
            push_q     <= 1'b0;
            sel_q      <= '0;
            break_q    <= 1'b0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            id_push_q  <= id_push_d;
            id_value_q <= id_value_d;
            push_q     <= push_d;
            sel_q      <= sel_d;
            break_q    <= break_d;
            update_q   <= update_d;
            err_q      <= err_d;
        end
    end

    // In-flight ID counter: +1 per ID push, -1 per commit pull, saturating at both ends
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else begin
            case ({id_push_q, commit_pull})
                2'b10: if (inflight_q < INF_WIDTH'(DEPTH)) inflight_q <= inflight_q + INF_WIDTH'(1);
                2'b01: if (inflight_q != '0)               inflight_q <= inflight_q - INF_WIDTH'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Drain register: load on pull, empty when the consumer takes the held ID
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else if (commit_pull) begin
            out_valid_q <= 1'b1;
            out_id_q    <= bus.commit_id_value_i;
        end else if (bus.out_ready_i && out_valid_q) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready_o      = req_ready;
    assign bus.sel_ready_o      = sel_ready;
    assign bus.trace_id_push_o  = id_push_q;
    assign bus.trace_id_value_o = id_value_q;
    assign bus.trace_push_o     = push_q;
    assign bus.trace_sel_o      = sel_q;
    assign bus.trace_break_o    = break_q;
    assign bus.trace_update_o   = update_q;
    assign bus.commit_id_pull_o = commit_pull;
    assign bus.out_valid_o      = out_valid_q;
    assign bus.out_id_o         = out_id_q;
    assign bus.busy_o           = (state_q == ENTRY);
    assign bus.err_o            = err_q;
endmodule

// File: tb/tb_reorder_trace_sequencer.sv
// Self-checking bench for reorder_trace_sequencer: directed scenarios followed
// by randomized traffic. All of it is compared cycle by cycle against a
// transaction-level reference model.
module tb_reorder_trace_sequencer;
    localparam int   NQ = 4;
    localparam int   D  = 8;
    localparam int   ME = 8;
    localparam logic BP = 1'b1;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    reorder_trace_sequencer_if #(.NUM_QUEUES(NQ), .DEPTH(D), .MAX_ENTRIES(ME)) bus();

    reorder_trace_sequencer #(
        .NUM_QUEUES(NQ), .DEPTH(D), .MAX_ENTRIES(ME), .BREAKPOINT(BP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus applied by step()
    bit s_rst, s_req_valid, s_sel_valid, s_abort, s_full, s_cvalid, s_out_ready;
    int s_req_id, s_req_count, s_sel, s_cvalue;

    // Reference model: trace context, in-flight count, drain register and the
    // trace outputs expected to be visible in the current cycle.
    bit m_busy, m_first, m_outv;
    int m_id, m_rem, m_inflight, m_outid;
    bit e_push, e_idpush, e_brk, e_upd, e_err;
    int e_sel, e_idval;

    // Observations
    int  obs_push, obs_idpush, obs_upd, obs_err;
    bit  last_req_hs, last_sel_hs, last_pull;
    int  out_log[$];

    task automatic model_reset();
        m_busy = 0; m_first = 0; m_outv = 0;
        m_id = 0; m_rem = 0; m_inflight = 0; m_outid = 0;
        e_push = 0; e_idpush = 0; e_brk = 0; e_upd = 0; e_err = 0;
        e_sel = 0; e_idval = 0;
    endtask

    task automatic idle_inputs();
        s_rst = 0; s_req_valid = 0; s_sel_valid = 0; s_abort = 0;
        s_full = 0; s_cvalid = 0; s_out_ready = 1;
        s_req_id = 0; s_req_count = 0; s_sel = 0; s_cvalue = 0;
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model
    task automatic step();
        bit x_req_ready, x_sel_ready, x_pull, req_hs, sel_hs;
        bit n_push, n_idpush, n_brk, n_upd, n_err;
        int n_sel, n_idval;
        @(negedge clk);
        rst_i                 = s_rst;
        bus.req_valid_i       = s_req_valid;
        bus.req_id_i          = 3'(s_req_id);
        bus.req_count_i       = 4'(s_req_count);
        bus.sel_valid_i       = s_sel_valid;
        bus.sel_i             = 2'(s_sel);
        bus.abort_i           = s_abort;
        bus.full_i            = s_full;
        bus.commit_id_valid_i = s_cvalid;
        bus.commit_id_value_i = 3'(s_cvalue);
        bus.out_ready_i       = s_out_ready;
        #1;
        // A visible ID push already counts against the in-flight limit.
        x_req_ready = !m_busy && !s_full && (m_inflight + int'(e_idpush) < D);
        x_sel_ready = m_busy && !s_full && !s_abort;
        x_pull      = s_cvalid && (!m_outv || s_out_ready);

        check("req_ready",   bus.req_ready_o,      x_req_ready);
        check("sel_ready",   bus.sel_ready_o,      x_sel_ready);
        check("commit_pull", bus.commit_id_pull_o, x_pull);
        check("busy",        bus.busy_o,           m_busy);
        check("trace_push",  bus.trace_push_o,     e_push);
        check("trace_sel",   bus.trace_sel_o,      e_sel);
        check("trace_break", bus.trace_break_o,    e_brk);
        check("id_push",     bus.trace_id_push_o,  e_idpush);
        check("id_value",    bus.trace_id_value_o, e_idval);
        check("update",      bus.trace_update_o,   e_upd);
        check("err",         bus.err_o,            e_err);
        check("out_valid",   bus.out_valid_o,      m_outv);
        check("out_id",      bus.out_id_o,         m_outid);

        if (bus.trace_push_o === 1'b1)    obs_push++;
        if (bus.trace_id_push_o === 1'b1) obs_idpush++;
        if (bus.trace_update_o === 1'b1)  obs_upd++;
        if (bus.err_o === 1'b1)           obs_err++;
        if (!s_rst && bus.out_valid_o === 1'b1 && s_out_ready) out_log.push_back(int'(bus.out_id_o));
        req_hs      = s_req_valid && x_req_ready;
        sel_hs      = s_sel_valid && x_sel_ready;
        last_req_hs = req_hs;
        last_sel_hs = sel_hs;
        last_pull   = x_pull;

        n_push = 0; n_idpush = 0; n_brk = 0; n_upd = 0; n_err = 0; n_sel = 0; n_idval = 0;
        if (s_rst) begin
            model_reset();
        end else begin
            if (e_idpush && !x_pull && m_inflight < D) m_inflight++;
            else if (x_pull && !e_idpush && m_inflight > 0) m_inflight--;

            if (!m_busy) begin
                if (req_hs) begin
                    if (s_req_count >= 1 && s_req_count <= ME) begin
                        m_busy = 1; m_id = s_req_id; m_rem = s_req_count; m_first = 1;
                    end else begin
                        n_err = 1;
                    end
                end
            end else if (s_abort) begin
                n_upd  = !m_first;
                m_busy = 0;
            end else if (sel_hs) begin
                n_push   = 1;
                n_sel    = s_sel;
                n_idpush = m_first;
                n_idval  = m_id;
                n_brk    = (m_rem == 1) ? BP : !BP;
                m_first  = 0;
                m_rem    = m_rem - 1;
                if (m_rem == 0) m_busy = 0;
            end

            if (x_pull) begin
                m_outv = 1; m_outid = s_cvalue;
            end else if (s_out_ready && m_outv) begin
                m_outv = 0;
            end
            e_push = n_push; e_sel = n_sel; e_idpush = n_idpush; e_idval = n_idval;
            e_brk = n_brk; e_upd = n_upd; e_err = n_err;
        end
    endtask

    // Offer a request until it is accepted (bounded)
    task automatic send_req(input int id, input int count);
        bit done = 0;
        s_req_valid = 1; s_req_id = id; s_req_count = count;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = last_req_hs;
        end
        s_req_valid = 0;
        if (!done) check("req_timeout", 0, 1);
    endtask

    // Offer one selector until it is consumed (bounded)
    task automatic send_sel(input int sel);
        bit done = 0;
        s_sel_valid = 1; s_sel = sel;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = last_sel_hs;
        end
        s_sel_valid = 0;
        if (!done) check("sel_timeout", 0, 1);
    endtask

    initial begin
        int p0, ip0, u0, e0;
        int pend[$];
        bit rdy_pat[4];
        idle_inputs();
        obs_push = 0; obs_idpush = 0; obs_upd = 0; obs_err = 0;
        rst_i = 1'b1;
        bus.req_valid_i = 0; bus.req_id_i = '0; bus.req_count_i = '0;
        bus.sel_valid_i = 0; bus.sel_i = '0; bus.abort_i = 0; bus.full_i = 0;
        bus.commit_id_valid_i = 0; bus.commit_id_value_i = '0; bus.out_ready_i = 1;
        repeat (2) @(posedge clk);
        model_reset();
        step();   // reset state is compared here

        // Back-to-back trace: id 5, selectors 2,0,3
        p0 = obs_push; ip0 = obs_idpush;
        send_req(5, 3);
        s_sel_valid = 1;
        s_sel = 2; step();
        s_sel = 0; step();
        s_sel = 3; step();
        s_sel_valid = 0;
        repeat (2) step();
        check("s1_pushes", obs_push - p0, 3);
        check("s1_id_pushes", obs_idpush - ip0, 1);

        // full_i during cycles 2-4 of a count=4 trace
        p0 = obs_push;
        send_req(2, 4);
        s_sel_valid = 1;
        for (int i = 0; i < 10; i++) begin
            s_full = (i >= 1 && i <= 3);
            s_sel  = i % NQ;
            step();
        end
        s_sel_valid = 0; s_full = 0;
        step();
        check("s2_pushes", obs_push - p0, 4);

        // In-flight limit: 8 single-entry traces, no commits
        s_rst = 1; step(); s_rst = 0;
        for (int k = 0; k < D; k++) begin
            send_req(k, 1);
            send_sel(k % NQ);
        end
        repeat (2) step();
        check("limit_ready_low", bus.req_ready_o, 0);
        s_cvalid = 1; s_cvalue = 4; step();
        s_cvalid = 0; step();
        check("limit_ready_back", bus.req_ready_o, 1);
        s_cvalid = 1;
        repeat (D) step();
        s_cvalid = 0;
        repeat (2) step();

        // Abort after two pushes, then abort before the first selector
        p0 = obs_push; u0 = obs_upd;
        send_req(6, 4);
        send_sel(1);
        send_sel(2);
        s_abort = 1; step(); s_abort = 0;
        s_sel_valid = 1; repeat (3) step(); s_sel_valid = 0;
        check("abort_pushes", obs_push - p0, 2);
        check("abort_update", obs_upd - u0, 1);
        check("abort_idle", bus.busy_o, 0);
        ip0 = obs_idpush; u0 = obs_upd;
        send_req(1, 3);
        s_abort = 1; step(); s_abort = 0;
        repeat (2) step();
        check("early_abort_idpush", obs_idpush - ip0, 0);
        check("early_abort_update", obs_upd - u0, 0);

        // Illegal counts 0 and 9
        e0 = obs_err; p0 = obs_push;
        send_req(3, 0); step();
        send_req(3, 9); step();
        check("err_pulses", obs_err - e0, 2);
        check("err_no_push", obs_push - p0, 0);
        check("err_idle", bus.busy_o, 0);

        // Commit drain 3,1,6 with out_ready 1,0,1,1
        out_log.delete();
        pend = '{3, 1, 6};
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            s_out_ready = (c < 4) ? rdy_pat[c] : 1'b1;
            s_cvalid    = (pend.size() > 0);
            s_cvalue    = (pend.size() > 0) ? pend[0] : 0;
            step();
            if (last_pull && pend.size() > 0) void'(pend.pop_front());
        end
        s_cvalid = 0; s_out_ready = 1;
        check("drain_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("drain_0", out_log[0], 3);
            check("drain_1", out_log[1], 1);
            check("drain_2", out_log[2], 6);
        end

        // Reset in the middle of a trace
        u0 = obs_upd;
        send_req(3, 4);
        send_sel(0);
        send_sel(1);
        s_rst = 1; step(); s_rst = 0;
        repeat (3) step();
        check("rst_no_update", obs_upd - u0, 0);
        check("rst_idle", bus.busy_o, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            s_rst       = ($urandom % 250 == 0);
            s_req_valid = ($urandom % 3 == 0);
            s_req_id    = $urandom % D;
            if ($urandom % 8 == 0) s_req_count = ($urandom % 2) ? 0 : 9 + $urandom % 7;
            else                   s_req_count = 1 + $urandom % ME;
            s_sel_valid = ($urandom % 4 != 0);
            s_sel       = $urandom % NQ;
            s_abort     = ($urandom % 20 == 0);
            s_full      = ($urandom % 5 == 0);
            s_cvalid    = ($urandom % 3 == 0);
            s_cvalue    = $urandom % D;
            s_out_ready = ($urandom % 3 != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
